mux_nto1_serializer: RTL

Parametrised N:1 registered serializing multiplexer for the PHY transmit path. It replaces the fixed 2:1 per-level mux stages, so one instance collapses a whole mux tree. In the fast clock domain it snapshots LANES parallel lanes once per frame. It then emits them one lane per cycle with a per-slot valid bit and lane index. An alignment state machine locks the slot counter to an external frame marker and flags misalignment.

---
 rtl/mux_nto1_serializer.sv | 88 ++++++++
 1 files changed

// File: rtl/mux_nto1_serializer.sv
// N:1 registered serializing multiplexer: snapshots LANES lanes at slot 0 of each
// frame and emits one lane per clk_4f cycle, locked to an external frame marker.
module mux_nto1_serializer #(
  parameter int WIDTH           = 8,
  parameter int LANES           = 4,
  parameter int HOLD_ON_INVALID = 1
) (
  input  logic                       clk_4f,
  input  logic                       reset_L,
  input  logic                       align,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic [LANES-1:0]           in_valid,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(LANES)-1:0]   lane_out,
  output logic                       realign_err
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_SLOT = CW'(LANES - 1);

  typedef enum logic {
    WAIT_ALIGN,
    RUN
  } state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [LANES*WIDTH-1:0]   snap_d;
  logic [LANES-1:0]         snap_v;
  logic [WIDTH-1:0]         sel_d;
  logic                     sel_v;

  // Slot 0 bypasses the snapshot so lane 0 leaves with no extra latency.
  always_comb begin
    sel_d = snap_d[int'(cnt)*WIDTH +: WIDTH];
    sel_v = snap_v[cnt];
    if (cnt == '0) begin
      sel_d = in_data[WIDTH-1:0];
      sel_v = in_valid[0];
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= WAIT_ALIGN;
      cnt         <= '0;
      snap_d      <= '0;
      snap_v      <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      lane_out    <= '0;
      realign_err <= 1'b0;
    end else begin
      realign_err <= 1'b0;
      case (state)
        WAIT_ALIGN: begin
          valid_out <= 1'b0;
          lane_out  <= '0;
          if (HOLD_ON_INVALID == 0) data_out <= '0;
          if (align) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            snap_d <= in_data;
            snap_v <= in_valid;
          end
          valid_out <= sel_v;
          if (sel_v) data_out <= sel_d;
          else if (HOLD_ON_INVALID == 0) data_out <= '0;
          lane_out <= cnt;
          // A marker on the last slot coincides with the natural wrap and is not an error.
          if (align) begin
            cnt         <= '0;
            realign_err <= (cnt != LAST_SLOT);
          end else begin
            cnt <= (cnt == LAST_SLOT) ? '0 : cnt + 1'b1;
          end
        end
        default: state <= WAIT_ALIGN;
      endcase
    end
  end

endmodule
